// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Sequencer and two-requester round-robin arbiter in front of a shared,
//   purely combinational ALU. Each requester hands over one operation at a
//   time (valid/ready). The winning operation is registered onto the ALU
//   inputs, held for ALU_LAT cycles, then the ALU outputs are captured into
//   that requester's response buffer. A carry flag is kept per requester so
//   interleaved multi-word add/sub chains stay independent.
//
// Parameters
//   WIDTH   : operand/result width
//   OPW     : opcode width (opcode is passed to the ALU undecoded)
//   ALU_LAT : cycles the ALU inputs are held before sampling (1..15)
//
// Ports
//   clk, rst                      : clock, synchronous active-high reset
//   reqN_valid/ready              : request handshake, N = 0,1
//   reqN_a, reqN_b, reqN_op       : operands and opcode
//   reqN_use_c                    : carry-in = requester's saved carry flag
//   rspN_valid/ready              : response handshake
//   rspN_result, rspN_c/z/n       : captured ALU ans1, ans2, Z, N
//   alu_a, alu_b, alu_op, alu_c   : registered drive to the ALU
//   alu_ans1, alu_ans2, alu_z/n   : ALU outputs
//   busy                          : an operation is executing
//   grant_id                      : owner of the current or last operation
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 6,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req0_use_c,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic             req1_use_c,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_c,
  output logic             rsp0_z,
  output logic             rsp0_n,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_c,
  output logic             rsp1_z,
  output logic             rsp1_n,

  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_c,
  input  logic [WIDTH-1:0] alu_ans1,
  input  logic             alu_ans2,
  input  logic             alu_z,
  input  logic             alu_n,

  output logic             busy,
  output logic             grant_id
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  // The counter is loaded with ALU_LAT-1 so that the capture edge lands
  // exactly ALU_LAT edges after the handshake edge.
  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       aluA_q, aluA_d;
  logic [WIDTH-1:0]       aluB_q, aluB_d;
  logic [OPW-1:0]         aluOp_q, aluOp_d;
  logic                   aluC_q, aluC_d;
  logic                   lastGrant_q, lastGrant_d;
  logic [1:0]             cflag_q, cflag_d;
  logic [1:0]             rspValid_q, rspValid_d;
  logic [1:0][WIDTH-1:0]  rspResult_q, rspResult_d;
  logic [1:0]             rspCarry_q, rspCarry_d;
  logic [1:0]             rspZero_q, rspZero_d;
  logic [1:0]             rspNeg_q, rspNeg_d;

  logic [1:0]             eligible;
  logic [1:0]             rspReady;
  logic                   grantSel;
  logic                   handshake;
  logic [WIDTH-1:0]       selA;
  logic [WIDTH-1:0]       selB;
  logic [OPW-1:0]         selOp;
  logic                   selUseC;

  // A requester whose previous response is still registered as valid is not
  // eligible, even if that response is being consumed this very cycle.
  assign eligible = {req1_valid & ~rspValid_q[1], req0_valid & ~rspValid_q[0]};
  assign rspReady = {rsp1_ready, rsp0_ready};

  // Round-robin pick: a sole eligible requester wins; on a tie the one that
  // was not granted last time wins.
  always_comb begin
    grantSel = 1'b0;
    case (eligible)
      2'b10:   grantSel = 1'b1;
      2'b11:   grantSel = ~lastGrant_q;
      default: grantSel = 1'b0;
    endcase
  end

  assign handshake  = (state_q == IDLE) && eligible[grantSel];
  assign req0_ready = handshake & ~grantSel;
  assign req1_ready = handshake & grantSel;

  assign selA    = grantSel ? req1_a     : req0_a;
  assign selB    = grantSel ? req1_b     : req0_b;
  assign selOp   = grantSel ? req1_op    : req0_op;
  assign selUseC = grantSel ? req1_use_c : req0_use_c;

  // Next-state and datapath update. Response buffers drop valid when
  // consumed; a capture for the owner always targets a buffer that was empty
  // at grant time, so capture and consume never collide on one requester.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aluA_d      = aluA_q;
    aluB_d      = aluB_q;
    aluOp_d     = aluOp_q;
    aluC_d      = aluC_q;
    lastGrant_d = lastGrant_q;
    cflag_d     = cflag_q;
    rspValid_d  = rspValid_q & ~rspReady;
    rspResult_d = rspResult_q;
    rspCarry_d  = rspCarry_q;
    rspZero_d   = rspZero_q;
    rspNeg_d    = rspNeg_q;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          aluA_d      = selA;
          aluB_d      = selB;
          aluOp_d     = selOp;
          aluC_d      = selUseC & cflag_q[grantSel];
          lastGrant_d = grantSel;
          cnt_d       = LAT_M1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rspResult_d[lastGrant_q] = alu_ans1;
          rspCarry_d[lastGrant_q]  = alu_ans2;
          rspZero_d[lastGrant_q]   = alu_z;
          rspNeg_d[lastGrant_q]    = alu_n;
          rspValid_d[lastGrant_q]  = 1'b1;
          cflag_d[lastGrant_q]     = alu_ans2;
          state_d                  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset discards any in-flight operation; grant history
  // resets to requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      aluA_q      <= '0;
      aluB_q      <= '0;
      aluOp_q     <= '0;
      aluC_q      <= 1'b0;
      lastGrant_q <= 1'b1;
      cflag_q     <= 2'b00;
      rspValid_q  <= 2'b00;
      rspResult_q <= '0;
      rspCarry_q  <= 2'b00;
      rspZero_q   <= 2'b00;
      rspNeg_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aluA_q      <= aluA_d;
      aluB_q      <= aluB_d;
      aluOp_q     <= aluOp_d;
      aluC_q      <= aluC_d;
      lastGrant_q <= lastGrant_d;
      cflag_q     <= cflag_d;
      rspValid_q  <= rspValid_d;
      rspResult_q <= rspResult_d;
      rspCarry_q  <= rspCarry_d;
      rspZero_q   <= rspZero_d;
      rspNeg_q    <= rspNeg_d;
    end
  end

  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_op      = aluOp_q;
  assign alu_c       = aluC_q;

  assign rsp0_valid  = rspValid_q[0];
  assign rsp0_result = rspResult_q[0];
  assign rsp0_c      = rspCarry_q[0];
  assign rsp0_z      = rspZero_q[0];
  assign rsp0_n      = rspNeg_q[0];

  assign rsp1_valid  = rspValid_q[1];
  assign rsp1_result = rspResult_q[1];
  assign rsp1_c      = rspCarry_q[1];
  assign rsp1_z      = rspZero_q[1];
  assign rsp1_n      = rspNeg_q[1];

  assign busy        = (state_q == EXEC);
  assign grant_id    = lastGrant_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter
//   Drives alu_arbiter (ALU_LAT=1) with directed and random traffic against a
//   cycle-count reference model and a response scoreboard, and a second
//   instance (ALU_LAT=4) for the latency/hold behaviour.
module tb_alu_arbiter;

  localparam int         W      = 32;
  localparam int         LAT    = 1;
  localparam int         LAT_B  = 4;
  localparam logic [5:0] OP_ADD = 6'b010000;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;

  logic [1:0]  reqValid, reqReady, reqUseC, rspValid, rspReady, rspC, rspZ, rspNg;
  logic [31:0] reqA [2];
  logic [31:0] reqB [2];
  logic [5:0]  reqOp [2];
  logic [31:0] rsp0Res, rsp1Res;
  logic [31:0] aluA, aluB, aluAns1;
  logic [5:0]  aluOp;
  logic        aluC, aluAns2, aluZ, aluN, busy, grantId;

  logic        bValid, bReady0, bReady1, bRspValid0, bRspValid1;
  logic        bRspC0, bRspZ0, bRspN0, bRspC1, bRspZ1, bRspN1;
  logic [31:0] bA, bB, bRes0, bRes1, bAluA, bAluB, bAluAns1;
  logic [5:0]  bOp, bAluOp;
  logic        bAluC, bAluAns2, bAluZ, bAluN, bBusy, bGrant;

  int   total = 0;
  int   bad   = 0;

  // reference model state
  bit   known = 0;
  bit   inExec = 0;
  bit   resetNext = 0;
  bit   mLast = 1;
  bit   hsSeen = 0;
  int   hsWho = 0;
  bit [1:0] mPend = 0, mCflag = 0, clearNext = 0;
  int   doneAt = 0;
  int   cyc = 0;
  rsp_t expQ0[$];
  rsp_t expQ1[$];

  always #5 clk = ~clk;

  // stand-in ALU: op 010000 adds with carry, anything else xors in the
  // opcode and passes carry-in straight through to ans2
  function automatic logic [W+2:0] stubAlu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [5:0] op, input logic c);
    logic [W:0] s;
    if (op == OP_ADD) s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    else              s = {c, a ^ b ^ 32'(op)};
    return {s[W-1], (s[W-1:0] == '0), s};
  endfunction

  assign {aluN, aluZ, aluAns2, aluAns1}     = stubAlu(aluA, aluB, aluOp, aluC);
  assign {bAluN, bAluZ, bAluAns2, bAluAns1} = stubAlu(bAluA, bAluB, bAluOp, bAluC);

  alu_arbiter #(.WIDTH(W), .OPW(6), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(reqValid[0]), .req0_ready(reqReady[0]), .req0_a(reqA[0]), .req0_b(reqB[0]),
    .req0_op(reqOp[0]), .req0_use_c(reqUseC[0]),
    .req1_valid(reqValid[1]), .req1_ready(reqReady[1]), .req1_a(reqA[1]), .req1_b(reqB[1]),
    .req1_op(reqOp[1]), .req1_use_c(reqUseC[1]),
    .rsp0_valid(rspValid[0]), .rsp0_ready(rspReady[0]), .rsp0_result(rsp0Res),
    .rsp0_c(rspC[0]), .rsp0_z(rspZ[0]), .rsp0_n(rspNg[0]),
    .rsp1_valid(rspValid[1]), .rsp1_ready(rspReady[1]), .rsp1_result(rsp1Res),
    .rsp1_c(rspC[1]), .rsp1_z(rspZ[1]), .rsp1_n(rspNg[1]),
    .alu_a(aluA), .alu_b(aluB), .alu_op(aluOp), .alu_c(aluC),
    .alu_ans1(aluAns1), .alu_ans2(aluAns2), .alu_z(aluZ), .alu_n(aluN),
    .busy(busy), .grant_id(grantId)
  );

  alu_arbiter #(.WIDTH(W), .OPW(6), .ALU_LAT(LAT_B)) dutB (
    .clk(clk), .rst(rst),
    .req0_valid(bValid), .req0_ready(bReady0), .req0_a(bA), .req0_b(bB),
    .req0_op(bOp), .req0_use_c(1'b0),
    .req1_valid(1'b0), .req1_ready(bReady1), .req1_a(32'd0), .req1_b(32'd0),
    .req1_op(6'd0), .req1_use_c(1'b0),
    .rsp0_valid(bRspValid0), .rsp0_ready(1'b0), .rsp0_result(bRes0),
    .rsp0_c(bRspC0), .rsp0_z(bRspZ0), .rsp0_n(bRspN0),
    .rsp1_valid(bRspValid1), .rsp1_ready(1'b0), .rsp1_result(bRes1),
    .rsp1_c(bRspC1), .rsp1_z(bRspZ1), .rsp1_n(bRspN1),
    .alu_a(bAluA), .alu_b(bAluB), .alu_op(bAluOp), .alu_c(bAluC),
    .alu_ans1(bAluAns1), .alu_ans2(bAluAns2), .alu_z(bAluZ), .alu_n(bAluN),
    .busy(bBusy), .grant_id(bGrant)
  );

  // reference arithmetic, done in 64 bits
  function automatic rsp_t refOp(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    rsp_t r;
    logic [63:0] s;
    if (op == OP_ADD) begin
      s = {32'd0, a} + {32'd0, b} + {63'd0, cin};
      r.res = s[31:0];
      r.c   = s[32];
    end else begin
      r.res = a ^ b ^ 32'(op);
      r.c   = cin;
    end
    r.z = (r.res == 32'd0);
    r.n = r.res[31];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input int n, input bit v, input logic [31:0] a,
                               input logic [31:0] b, input logic [5:0] op, input bit uc);
    reqValid[n] = v;
    reqA[n]     = a;
    reqB[n]     = b;
    reqOp[n]    = op;
    reqUseC[n]  = uc;
  endtask

  // model bookkeeping right after an edge
  task automatic modelEdge();
    if (resetNext) begin
      known = 1; inExec = 0; mPend = 0; mCflag = 0; mLast = 1; clearNext = 0;
      resetNext = 0;
      expQ0.delete();
      expQ1.delete();
    end else if (known) begin
      mPend = mPend & ~clearNext;
      clearNext = 0;
      if (inExec && cyc == doneAt) begin
        mPend[mLast] = 1'b1;
        inExec = 0;
      end
    end
  endtask

  task automatic checkCycle();
    if (!known) return;
    checkBit("busy", busy, inExec);
    checkBit("rsp0_valid", rspValid[0], mPend[0]);
    checkBit("rsp1_valid", rspValid[1], mPend[1]);
    checkBit("grant_id", grantId, mLast);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    modelEdge();
    checkCycle();
  endtask

  // inputs are settled: predict readies and what the coming edge does
  task automatic settle();
    bit e0, e1, pick;
    bit [1:0] expRdy;
    logic cin;
    rsp_t r;
    #1;
    hsSeen = 0;
    expRdy = 2'b00;
    pick = 0;
    if (known && !inExec) begin
      e0 = reqValid[0] && !mPend[0];
      e1 = reqValid[1] && !mPend[1];
      if (e0 && e1) pick = (mLast == 1'b1) ? 1'b0 : 1'b1;
      else          pick = e1;
      if (e0 || e1) expRdy[pick] = 1'b1;
    end
    if (known) begin
      checkBit("req0_ready", reqReady[0], expRdy[0]);
      checkBit("req1_ready", reqReady[1], expRdy[1]);
    end
    if (rst) begin
      resetNext = 1;
    end else if (known) begin
      if (expRdy != 2'b00) begin
        cin = reqUseC[pick] ? mCflag[pick] : 1'b0;
        r = refOp(reqOp[pick], reqA[pick], reqB[pick], cin);
        if (pick == 1'b0) expQ0.push_back(r);
        else              expQ1.push_back(r);
        mCflag[pick] = r.c;
        mLast  = pick;
        inExec = 1;
        doneAt = cyc + 1 + LAT;
        hsSeen = 1;
        hsWho  = int'(pick);
      end
      clearNext = mPend & rspReady;
    end
  endtask

  // scoreboard monitor: a consumed response is popped and compared
  task automatic popCompare(input int n);
    rsp_t e;
    logic [31:0] act;
    act = (n == 0) ? rsp0Res : rsp1Res;
    if ((n == 0 && expQ0.size() == 0) || (n == 1 && expQ1.size() == 0)) begin
      total++;
      bad++;
      $display("[TB] FAIL rsp%0d_unexpected at cycle %0d: got result %h, expected none", n, cyc, act);
      return;
    end
    if (n == 0) e = expQ0.pop_front();
    else        e = expQ1.pop_front();
    checkOutput($sformatf("rsp%0d_result", n), act, e.res);
    checkBit($sformatf("rsp%0d_c", n), rspC[n], e.c);
    checkBit($sformatf("rsp%0d_z", n), rspZ[n], e.z);
    checkBit($sformatf("rsp%0d_n", n), rspNg[n], e.n);
  endtask

  always @(negedge clk) begin
    if (known) begin
      for (int n = 0; n < 2; n++) begin
        if (rspValid[n] === 1'b1 && rspReady[n] === 1'b1) popCompare(n);
      end
    end
  end

  task automatic runOp(input int n, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] op, input bit uc);
    bit acc;
    acc = 0;
    applyStimulus(n, 1, a, b, op, uc);
    for (int i = 0; i < 20 && !acc; i++) begin
      settle();
      acc = hsSeen && (hsWho == n);
      tick();
    end
    applyStimulus(n, 0, a, b, op, uc);
    if (!acc) begin
      total++;
      bad++;
      $display("[TB] FAIL req%0d_accept_timeout at cycle %0d: got no ready, expected ready", n, cyc);
      return;
    end
    for (int i = 0; i < LAT + 6 && !mPend[n]; i++) begin
      settle();
      tick();
    end
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    rspReady = 2'b11;
    repeat (2) begin
      settle();
      tick();
    end
    rspReady = 2'b00;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_rsp0_result", rsp0Res, 32'd0);
    checkOutput("rst_rsp1_result", rsp1Res, 32'd0);
    checkOutput("rst_rsp_flags", {26'd0, rspC, rspZ, rspNg}, 32'd0);
    checkOutput("rst_rsp_valid", {30'd0, rspValid}, 32'd0);
    checkOutput("rst_alu_a", aluA, 32'd0);
    checkOutput("rst_alu_b", aluB, 32'd0);
    checkOutput("rst_alu_op", {26'd0, aluOp}, 32'd0);
    checkBit("rst_alu_c", aluC, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_grant_id", grantId, 1'b1);
  endtask

  task automatic randomStimulus();
    logic [31:0] a, b;
    logic [5:0]  op;
    for (int n = 0; n < 2; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'h1 : $urandom();
      op = ($urandom_range(0, 1) == 0) ? OP_ADD : 6'($urandom());
      applyStimulus(n, ($urandom_range(0, 9) < 7), a, b, op, 1'($urandom()));
    end
    rspReady[0] = ($urandom_range(0, 9) < 6);
    rspReady[1] = ($urandom_range(0, 9) < 6);
    rst = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit expGrants[4];
    bit gotGrants[$];
    expGrants = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1;
    rspReady = 2'b00;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    bValid = 0; bA = 0; bB = 0; bOp = 0;
    repeat (2) begin
      settle();
      tick();
    end
    rst = 0;
    checkResetValues();
    $display("[TB] reset checked");

    // latency instance: one add, held for 4 cycles
    bValid = 1; bA = 32'h100; bB = 32'h23; bOp = OP_ADD;
    settle();
    checkBit("b_ready_first", bReady0, 1'b1);
    tick();
    bValid = 0;
    for (int k = 0; k < LAT_B; k++) begin
      checkBit("b_busy", bBusy, 1'b1);
      checkBit("b_rsp_early", bRspValid0, 1'b0);
      checkOutput("b_alu_a_hold", bAluA, 32'h100);
      checkOutput("b_alu_b_hold", bAluB, 32'h23);
      checkOutput("b_alu_op_hold", {26'd0, bAluOp}, {26'd0, OP_ADD});
      settle();
      tick();
    end
    checkBit("b_busy_end", bBusy, 1'b0);
    checkBit("b_rsp_valid", bRspValid0, 1'b1);
    checkOutput("b_result", bRes0, 32'h123);

    // single op on req0
    runOp(0, 32'h14, 32'h09, OP_ADD, 0);
    checkOutput("single_result", rsp0Res, 32'h1D);
    checkOutput("single_flags", {29'd0, rspC[0], rspZ[0], rspNg[0]}, 32'd0);
    checkBit("single_rsp1_idle", rspValid[1], 1'b0);
    checkOutput("single_rsp1_result", rsp1Res, 32'd0);
    drain();

    // carry chain on req1 with a req0 op in between
    runOp(1, 32'hFFFF_FFFF, 32'h1, OP_ADD, 0);
    checkOutput("chain_first", rsp1Res, 32'd0);
    checkBit("chain_first_c", rspC[1], 1'b1);
    checkBit("chain_first_z", rspZ[1], 1'b1);
    drain();
    runOp(0, 32'd0, 32'd0, OP_ADD, 1);
    checkOutput("chain_other_cin0", rsp0Res, 32'd0);
    drain();
    runOp(1, 32'd0, 32'd0, OP_ADD, 1);
    checkOutput("chain_second", rsp1Res, 32'h1);
    drain();

    // backpressure on rsp0 while both keep requesting
    applyStimulus(0, 1, 32'h7, 32'h8, OP_ADD, 1);
    applyStimulus(1, 1, 32'hA, 32'hB, 6'b000011, 1);
    rspReady = 2'b10;
    repeat (10) begin
      settle();
      tick();
    end
    rspReady = 2'b11;
    repeat (4) begin
      settle();
      tick();
    end
    drain();

    // set req1 carry, then reset in the middle of an operation
    runOp(1, 32'hFFFF_FFFF, 32'h2, OP_ADD, 0);
    drain();
    applyStimulus(1, 1, 32'h5, 32'h6, OP_ADD, 1);
    settle();
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkBit("midop_busy", busy, 1'b1);
    rst = 1;
    settle();
    tick();
    rst = 0;
    checkResetValues();

    // tie after reset: grants alternate starting with req0
    applyStimulus(0, 1, 32'd0, 32'd0, OP_ADD, 1);
    applyStimulus(1, 1, 32'd0, 32'd0, OP_ADD, 1);
    rspReady = 2'b11;
    repeat (10) begin
      settle();
      tick();
      if (busy === 1'b1) gotGrants.push_back(grantId);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < gotGrants.size()) checkBit($sformatf("tie_grant%0d", i), gotGrants[i], expGrants[i]);
      else begin
        total++;
        bad++;
        $display("[TB] FAIL tie_grant%0d: got no grant, expected %0d", i, expGrants[i]);
      end
    end
    drain();
    $display("[TB] directed phases done");

    // random traffic
    for (int i = 0; i < 500; i++) begin
      randomStimulus();
      settle();
      tick();
    end
    rst = 0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and two-requester round-robin arbiter for the shared 32-bit combinational `ALU` (operands a/b, 6-bit opCode, carry-in c; outputs ans1, ans2 carry-out, Z, N). Each requester submits one operation at a time over a valid/ready handshake. The block drives the ALU from registered operands for a programmable settle time and captures result and flags into a per-requester response buffer. It also keeps a per-requester carry flag, so multi-word add/sub chains from different requesters do not corrupt each other.

## Interface
- `WIDTH`, 32: operand/result width.
- `OPW`, 6: opcode width.
- `ALU_LAT`, 1: cycles the ALU inputs are held before sampling; legal range 1–15.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `reqN_valid` in 1 (N=0,1): operation request.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_a`, `reqN_b` in WIDTH: operands.
- `reqN_op` in OPW: ALU opcode; passed through without decoding.
- `reqN_use_c` in 1: 1 = carry-in is requester N's saved carry flag; 0 = carry-in 0.
- `rspN_valid` out 1: response N holds a result.
- `rspN_ready` in 1: response consumed.
- `rspN_result` out WIDTH: captured ans1.
- `rspN_c`, `rspN_z`, `rspN_n` out 1: captured ans2, Z, N.
- `alu_a`, `alu_b` out WIDTH: operands to the ALU.
- `alu_op` out OPW: opcode to the ALU.
- `alu_c` out 1: carry-in to the ALU.
- `alu_ans1` in WIDTH, `alu_ans2`, `alu_z`, `alu_n` in 1: ALU outputs.
- `busy` out 1: FSM in EXEC.
- `grant_id` out 1: owner of the current or last operation.

## Operation
- FSM has two states: IDLE and EXEC. Reset → IDLE.
- Eligibility: requester N is eligible when `reqN_valid && !rspN_valid`. `rspN_valid` is the registered value, so a response consumed in the same cycle still blocks that requester for that cycle.
- Arbitration in IDLE: grant the sole eligible requester. If both are eligible, grant the one that is not `last_grant`. `last_grant` resets to 1, so req0 wins the first tie.
- `reqN_ready` is combinational: 1 only in IDLE, and only for the granted eligible requester. At most one ready is high per cycle.
- Handshake (`valid && ready`) actions:
  - latch a, b and op into the operand registers;
  - set `alu_c_reg = use_c ? cflag[N] : 0`;
  - set `owner = N`, `last_grant = N`;
  - load the counter with ALU_LAT-1;
  - go to EXEC.
- `alu_a`, `alu_b`, `alu_op`, `alu_c` always come from the operand registers. They hold their last value in IDLE; all reset to 0.
- EXEC with counter ≠ 0: decrement the counter.
- EXEC with counter = 0, at the edge:
  - capture `alu_ans1/ans2/z/n` into rsp[owner];
  - set `rsp[owner]_valid`;
  - set `cflag[owner] = alu_ans2`;
  - go to IDLE.
- A response buffer clears when `rspN_valid && rspN_ready`. Its data holds its value until the next capture.
- Carry flags update only on completion of the owner's operation, whatever the opcode.
- Opcode is not interpreted. All arithmetic, including wrap-around, is the ALU's. The block adds no width extension.

## Timing
- Reset values:
  - ready, `rspN_valid`, `busy`: 0;
  - `rspN_result`, `rspN_c/z/n`: 0;
  - `alu_*` outputs: 0;
  - `cflag[0]`, `cflag[1]`: 0;
  - `grant_id`: 1.
- Latency: handshake at edge E → `rspN_valid` high from edge E+ALU_LAT.
- Throughput: one operation per ALU_LAT+1 cycles. The next handshake is possible at edge E+ALU_LAT+1.
- `busy` is 1 exactly ALU_LAT cycles per operation.
- Both responses can be pending simultaneously. A requester with a pending response is skipped without stalling the other.
- Reset mid-EXEC: the operation is discarded, no response is produced, and carry flags clear.
- `rspN_ready` with `rspN_valid`=0 is ignored.

## Test plan
The bench ALU model defines 6'b010000 = add: ans1 = a+b+c, ans2 = carry-out.
- Single op: req0 {a=0x14, b=0x09, op=010000, use_c=0}, ALU_LAT=1 → rsp0 {result=0x1D, c=0, z=0, n=0} one edge after the handshake; rsp1 stays 0.
- Carry chain: req1 add 0xFFFFFFFF+0x1 → {result 0, c=1, z=1}. Then req1 add 0x0+0x0 with use_c=1 → result 0x1. In between, a req0 op with use_c=1 gets carry-in 0.
- Tie and round-robin: req0 and req1 valid continuously, responses drained immediately → grants 0,1,0,1. `reqN_ready` is never high simultaneously.
- Backpressure: rsp0_ready held 0 → req0 not granted again; req1 ops still complete. Raising rsp0_ready releases req0 on the following cycle.
- Latency parameter: ALU_LAT=4 → `busy` high for 4 cycles; `rsp_valid` at edge E+4; `alu_*` stable throughout.
- Reset mid-op: rst asserted in the EXEC cycle → no rsp_valid, all outputs 0, cflags 0. The next tie grants req0.
